// File: rtl/koggstone_pkg.sv
// Shared constants for the Kogge-Stone adder.
//   WIDTH  : operand width (power of two; 32 is the verified configuration)
//   LEVELS : prefix-tree depth, derived as $clog2(WIDTH)
package koggstone_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned LEVELS = $clog2(WIDTH);

endpackage : koggstone_pkg

// File: rtl/ks_black_cell.sv
// Kogge-Stone prefix black cell: merges a high (gh,ph) group with the
// adjacent low (gl,pl) group into one generate/propagate pair.
// Ports:
//   gh, ph : generate/propagate of the more-significant group
//   gl, pl : generate/propagate of the less-significant group
//   g, p   : combined group generate/propagate
module ks_black_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule : ks_black_cell

// File: rtl/koggstone_32.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in, carry-out and a
// single output register: {co,s} = a + b + ci, available one cycle after the
// operands are sampled.
// Ports:
//   clk : clock, rising-edge active
//   rst : synchronous active-high reset, clears s and co
//   s   : registered sum, modulo 2^WIDTH
//   co  : registered carry out of bit WIDTH-1
//   a   : operand A (unsigned)
//   b   : operand B (unsigned)
//   ci  : carry into bit 0
module koggstone_32
  import koggstone_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] s,
  output logic             co,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci
);

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;

  // gk[k][i] / pk[k][i]: group generate/propagate reaching down from bit i
  // after k prefix levels. gk[LEVELS][i] is the carry out of bit i.
  logic [LEVELS:0][WIDTH-1:0]   gk;
  logic [LEVELS-1:0][WIDTH-1:0] pk;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_comb;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // ci sits at position -1 with G=ci, P=0. Merging it into bit 0 up front
  // leaves position 0 with P=0, so every group that reaches bit 0 then spans
  // down to -1 and the tree stays WIDTH cells wide.
  ks_black_cell u_ci_fold (
    .gh (g_bit[0]),
    .ph (p_bit[0]),
    .gl (ci),
    .pl (1'b0),
    .g  (gk[0][0]),
    .p  (pk[0][0])
  );

  assign gk[0][WIDTH-1:1] = g_bit[WIDTH-1:1];
  assign pk[0][WIDTH-1:1] = p_bit[WIDTH-1:1];

  // Levels 0..LEVELS-2 produce both G and P. The last level only needs G
  // (its P would be unused), so it is built as a generate-only merge.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int unsigned D = 1 << k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_pos
      if (i < D) begin : g_pass
        assign gk[k+1][i] = gk[k][i];
        if (k < LEVELS - 1) begin : g_pass_p
          assign pk[k+1][i] = pk[k][i];
        end
      end else if (k < LEVELS - 1) begin : g_black
        ks_black_cell u_cell (
          .gh (gk[k][i]),
          .ph (pk[k][i]),
          .gl (gk[k][i-D]),
          .pl (pk[k][i-D]),
          .g  (gk[k+1][i]),
          .p  (pk[k+1][i])
        );
      end else begin : g_gray
        assign gk[k+1][i] = gk[k][i] | (pk[k][i] & gk[k][i-D]);
      end
    end
  end

  assign carry = gk[LEVELS];

  always_comb begin
    sum_comb    = '0;
    sum_comb[0] = p_bit[0] ^ ci;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      sum_comb[i] = p_bit[i] ^ carry[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s  <= '0;
      co <= 1'b0;
    end else begin
      s  <= sum_comb;
      co <= carry[WIDTH-1];
    end
  end

endmodule : koggstone_32

// File: tb/tb_koggstone_32.sv
module tb_koggstone_32;

  logic        clk;
  logic        rst;
  logic [31:0] s;
  logic        co;
  logic [31:0] a;
  logic [31:0] b;
  logic        ci;

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[$];

  koggstone_32 dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .co  (co),
    .a   (a),
    .b   (b),
    .ci  (ci)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] exp_s, input logic exp_co);
    vectors++;
    if (s !== exp_s || co !== exp_co) begin
      miscompares++;
      $display("FAIL %s: got s=%h co=%b, expected s=%h co=%b", name, s, co, exp_s, exp_co);
    end
  endtask

  // Drive between edges, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic r, input logic [31:0] x, input logic [31:0] y,
                       input logic c);
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
    ci  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic        rc;

    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    a   = 32'h1234_5678;
    b   = 32'h9ABC_DEF0;
    ci  = 1'b1;

    tbl.push_back('{32'd5,         32'd10,        1'b1, 32'd16,        1'b0});
    tbl.push_back('{32'd37,        32'd48,        1'b0, 32'd85,        1'b0});
    tbl.push_back('{32'd125,       32'd110,       1'b1, 32'd236,       1'b0});
    tbl.push_back('{32'd63,        32'd211,       1'b0, 32'd274,       1'b0});
    tbl.push_back('{32'd122,       32'd11,        1'b1, 32'd134,       1'b0});
    tbl.push_back('{32'd245,       32'd2,         1'b0, 32'd247,       1'b0});
    tbl.push_back('{32'd3,         32'd90,        1'b1, 32'd94,        1'b0});
    tbl.push_back('{32'd100,       32'd200,       1'b0, 32'd300,       1'b0});
    tbl.push_back('{32'd127,       32'd127,       1'b1, 32'd255,       1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h0,         1'b1, 32'h0,         1'b1});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h0,         1'b1});
    tbl.push_back('{32'h0,         32'h0,         1'b0, 32'h0,         1'b0});
    tbl.push_back('{32'h0,         32'h0,         1'b1, 32'h1,         1'b0});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h0,         1'b1});
    tbl.push_back('{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0});

    // Reset held with nonzero operands: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
      check("reset_hold", 32'h0, 1'b0);
    end

    // First edge after release carries the current operands through.
    apply(1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    check("reset_release", 32'h0, 1'b1);

    foreach (tbl[i]) begin
      apply(1'b0, tbl[i].a, tbl[i].b, tbl[i].ci);
      check($sformatf("table[%0d]", i), tbl[i].s, tbl[i].co);
    end

    // Mid-stream reset clears the register on the very next edge.
    apply(1'b0, 32'hAAAAAAAA, 32'h55555555, 1'b0);
    check("pre_midreset", 32'hFFFFFFFF, 1'b0);
    apply(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("midreset", 32'h0, 1'b0);
    apply(1'b0, 32'd100, 32'd200, 1'b0);
    check("post_midreset", 32'd300, 1'b0);

    // Back-to-back random operands, one per cycle.
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      case (n % 8)
        0: ra = 32'hFFFFFFFF;
        1: rb = ~ra;
        default: ;
      endcase
      r = ref_add(ra, rb, rc);
      apply(1'b0, ra, rb, rc);
      check("random", r[31:0], r[32]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule : tb_koggstone_32
